// File: rtl/pulse_meter_pkg.sv
//------------------------------------------------------------------------------
// Module      : pulse_meter_pkg
// Description : Shared state encoding and default width for pulse_meter.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package pulse_meter_pkg;

  localparam int PULSE_METER_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage : pulse_meter_pkg

`default_nettype wire

// File: rtl/pulse_meter_if.sv
//------------------------------------------------------------------------------
// Module      : pulse_meter_if
// Description : Valid/ready result port carrying the measured pulse width.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pulse_meter_if
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH = PULSE_METER_WIDTH_DEFAULT
);

  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] result;
  logic             result_sat;

  modport master (
    output result_valid,
    output result,
    output result_sat,
    input  result_ready
  );

  modport slave (
    input  result_valid,
    input  result,
    input  result_sat,
    output result_ready
  );

endinterface : pulse_meter_if

`default_nettype wire

// File: rtl/pulse_meter_rise_detect.sv
//------------------------------------------------------------------------------
// Module      : rise_detect
// Description : Registers the previous level and flags a 0->1 transition.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module rise_detect
  import pulse_meter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic level_in,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = level_in;
  end

  // Reset to 1 so a level already high when reset releases is not a rise.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = level_in & ~prev_q;

endmodule : rise_detect

`default_nettype wire

// File: rtl/pulse_meter.sv
//------------------------------------------------------------------------------
// Module      : pulse_meter
// Description : Measures high-pulse width in clocks; optional sticky overrun
//               flag for dropped pulses when PULSE_METER_OVERRUN_EN is defined.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pulse_meter
  import pulse_meter_pkg::*;
#(
  parameter int WIDTH = PULSE_METER_WIDTH_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          level_in,
  output logic          meas_busy,
  pulse_meter_if.master res
`ifdef PULSE_METER_OVERRUN_EN
  ,
  output logic          overrun
`endif
);

  localparam logic [WIDTH-1:0] COUNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q,      state_d;
  logic [WIDTH-1:0] count_q,      count_d;
  logic             sat_q,        sat_d;
  logic [WIDTH-1:0] result_q,     result_d;
  logic             result_sat_q, result_sat_d;
  logic             rise;

  rise_detect u_rise_detect (
    .clk      (clk),
    .reset    (reset),
    .level_in (level_in),
    .rise     (rise)
  );

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    sat_d        = sat_q;
    result_d     = result_q;
    result_sat_d = result_sat_q;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_MEAS;
          count_d = COUNT_ONE;
          sat_d   = 1'b0;
        end
      end
      ST_MEAS: begin
        if (level_in) begin
          if (&count_q) begin
            sat_d = 1'b1;
          end else begin
            count_d = count_q + COUNT_ONE;
          end
        end else begin
          state_d      = ST_HOLD;
          result_d     = count_q;
          result_sat_d = sat_q;
          sat_d        = 1'b0;
        end
      end
      ST_HOLD: begin
        // A rise coinciding with the handshake starts the next measurement;
        // any other rise while held drops that pulse entirely.
        if (res.result_ready) begin
          if (rise) begin
            state_d = ST_MEAS;
            count_d = COUNT_ONE;
            sat_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      sat_q        <= 1'b0;
      result_q     <= '0;
      result_sat_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      sat_q        <= sat_d;
      result_q     <= result_d;
      result_sat_q <= result_sat_d;
    end
  end

  assign meas_busy        = (state_q == ST_MEAS);
  assign res.result_valid = (state_q == ST_HOLD);
  assign res.result       = result_q;
  assign res.result_sat   = result_sat_q;

`ifdef PULSE_METER_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q | ((state_q == ST_HOLD) & rise & ~res.result_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule : pulse_meter

`default_nettype wire
